ws2812_rx: RTL and testbench
============================

Name: ws2812_rx

Overview:
- Receiver/decoder for the WS2812B single-wire NRZ LED protocol; the inverse of the strip driver.
- Samples a serial line (driver loopback or daisy-chain DOUT), measures high-pulse widths, reconstructs 24-bit GRB pixels with their index, and detects the frame latch gap.
- Used for on-board loopback self-test of the hologram pixel path. Also feeds MMIO status so the CPU can read the pixel and error counts.

Parameters:
- CLK_HZ, 100000000, system clock frequency; documentation only, all timing is in cycles.
- BIT_THRESH_CYC, 60, high-pulse width at or above this decodes to 1, below decodes to 0 (600 ns).
- MIN_HIGH_CYC, 10, high pulses shorter than this are glitches (100 ns).
- MAX_HIGH_CYC, 150, a high pulse reaching this is a timing error (1.5 us).
- RESET_CYC, 5000, continuous low time that constitutes the latch/reset gap (50 us).
- BITS_PER_PIXEL, 24, bits per pixel, MSB first, GRB order.
- PX_NUM, 52, expected pixels per frame.
- PX_COUNT_WIDTH, 6, width of pixel index/count.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- din  in  1  raw serial line; asynchronous to clk.
- err_clr  in  1  single-cycle pulse; clears sticky errors.
- pixel_valid  out  1  one-cycle strobe when pixel is new.
- pixel  out  BITS_PER_PIXEL  decoded GRB word; held until the next strobe.
- px_num  out  PX_COUNT_WIDTH  index of the pixel on the current strobe.
- frame_done  out  1  one-cycle strobe on latch detection.
- frame_px_count  out  PX_COUNT_WIDTH+1  pixels received in the last frame; held.
- err  out  3  sticky flags: [0] timing (glitch/overlong high), [1] partial pixel at latch, [2] overflow (more than PX_NUM pixels).
- synced  out  1  high once the receiver is frame-aligned.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0 and the FSM goes to S_SYNC.
  - Reset mid-frame discards all partial state.
- Input path: 2-flop synchronizer, then a registered previous-sample for edge detect. Rise/fall events are single-cycle.
- Latency: pixel_valid asserts exactly 4 clk after the din pin falling edge that ends bit 23.
- FSM:
  - S_SYNC: synced=0. A low counter runs while the synced input is 0 and clears on any 1. When it reaches RESET_CYC, go to S_IDLE and set synced=1. No frame_done is issued for this alignment gap.
  - S_IDLE: waiting for the first bit. On rise: high_cnt=1, go to S_HIGH.
  - S_HIGH: high_cnt increments each cycle.
    - high_cnt reaches MAX_HIGH_CYC: set err[0], go to S_SYNC.
    - On fall with high_cnt<MIN_HIGH_CYC: set err[0], go to S_SYNC.
    - On fall otherwise: bit=(high_cnt>=BIT_THRESH_CYC), shift into shift_reg LSB (MSB first on the wire), bit_cnt+1, low_cnt=1, go to S_LOW.
    - If bit_cnt reaches BITS_PER_PIXEL:
      - With px_cnt<PX_NUM: register pixel, px_num=px_cnt, pulse pixel_valid, px_cnt+1.
      - Otherwise: set err[2], no strobe.
      - In both cases bit_cnt=0.
  - S_LOW: low_cnt increments.
    - On rise: go to S_HIGH with high_cnt=1.
    - low_cnt reaches RESET_CYC: latch event.
  - Latch event:
    - pulse frame_done;
    - frame_px_count = px_cnt (saturates at PX_NUM);
    - if bit_cnt!=0, set err[1];
    - clear bit_cnt, px_cnt, shift_reg;
    - go to S_IDLE.
- Low-time limits: no minimum low time is enforced. Any rise before RESET_CYC continues the frame.
- Counters: high_cnt saturates at MAX_HIGH_CYC and low_cnt at RESET_CYC. Both are sized by $clog2 of their limit plus 1.
- err bits:
  - sticky; cleared only by err_clr or reset;
  - err_clr and a new error in the same cycle leave the bit set.
- pixel_valid and frame_done cannot coincide: a latch requires RESET_CYC low cycles after the last fall.

Decomposition:
- ws2812_pkg:
  - default timing constants (T0H/T1H/latch cycles at 100 MHz);
  - FSM state enum {S_SYNC, S_IDLE, S_HIGH, S_LOW};
  - err bit index constants;
  - GRB field offsets (G[23:16], R[15:8], B[7:0]).
- Sub-module ws2812_rx_sync: 2-flop synchronizer plus edge detector, outputs din_s, rise, fall.

Test Plan:
- 60 us low, then one pixel 0xFF0000 (T1H=80, T0H=40, bit period 125 cycles), then 50 us low -> synced=1; one pixel_valid with pixel=0xFF0000 and px_num=0; then frame_done with frame_px_count=1; err=0.
- Loop the strip driver output into din for a 52-pixel frame of a known ROM pattern -> 52 strobes, px_num 0..51, data matches, frame_px_count=52.
- 5-cycle high glitch mid-pixel -> err[0]=1, no strobe. Receiver resyncs after 5000 low cycles and the next frame decodes correctly.
- din held high for 200 cycles -> err[0] set at high_cnt=150, FSM in S_SYNC; err_clr -> err=0.
- 12 bits, then latch -> no strobe, err[1]=1, frame_done, frame_px_count=0. Separately, 53 pixels -> 52 strobes, err[2]=1.
- Assert reset after bit 10 of pixel 3 -> outputs 0 immediately. A new frame after a 50 us gap starts at px_num=0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared constants, state encoding and helpers for the WS2812B receive path.
package ws2812_pkg;

    // Nominal line timing at a 100 MHz system clock.
    localparam int unsigned CLK_HZ_DEF         = 100_000_000;
    localparam int unsigned T0H_CYC            = 40;
    localparam int unsigned T1H_CYC            = 80;
    localparam int unsigned BIT_PERIOD_CYC     = 125;
    localparam int unsigned LATCH_CYC          = 5000;

    // Decoder thresholds.
    localparam int unsigned BIT_THRESH_DEF     = 60;
    localparam int unsigned MIN_HIGH_DEF       = 10;
    localparam int unsigned MAX_HIGH_DEF       = 150;
    localparam int unsigned BITS_PER_PIXEL_DEF = 24;
    localparam int unsigned PX_NUM_DEF         = 52;
    localparam int unsigned PX_COUNT_WIDTH_DEF = 6;

    // Receiver states.
    typedef enum logic [1:0] {
        S_SYNC,
        S_IDLE,
        S_HIGH,
        S_LOW
    } rx_state_t;

    // Sticky error flag positions.
    localparam int unsigned ERR_TIMING   = 0;
    localparam int unsigned ERR_PARTIAL  = 1;
    localparam int unsigned ERR_OVERFLOW = 2;

    // GRB word layout, green transmitted first.
    localparam int unsigned COLOR_W = 8;
    localparam int unsigned G_LSB   = 16;
    localparam int unsigned R_LSB   = 8;
    localparam int unsigned B_LSB   = 0;

    // High time a driver uses for a given data bit.
    function automatic int unsigned bit_high_cyc(input logic b);
        return b ? T1H_CYC : T0H_CYC;
    endfunction

    // Remaining low time that completes a nominal bit period.
    function automatic int unsigned bit_low_cyc(input logic b);
        return BIT_PERIOD_CYC - bit_high_cyc(b);
    endfunction

    // Assemble a 24-bit GRB word from its colour channels.
    function automatic logic [23:0] grb_pack(input logic [7:0] g, input logic [7:0] r,
                                             input logic [7:0] b);
        logic [23:0] word;
        word = '0;
        word[G_LSB +: COLOR_W] = g;
        word[R_LSB +: COLOR_W] = r;
        word[B_LSB +: COLOR_W] = b;
        return word;
    endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// Brings the asynchronous serial line into the clock domain and flags its edges.
module ws2812_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic din_s,
    output logic rise,
    output logic fall
);

    logic din_meta;
    logic din_prev;

    // Two-flop synchronizer followed by a one-sample history for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
            din_prev <= 1'b0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;
            din_prev <= din_s;
        end
    end

    assign rise = din_s & ~din_prev;
    assign fall = ~din_s & din_prev;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812B line decoder: measures high pulses, rebuilds GRB pixels and detects the latch gap.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned CLK_HZ         = CLK_HZ_DEF,
    parameter int unsigned BIT_THRESH_CYC = BIT_THRESH_DEF,
    parameter int unsigned MIN_HIGH_CYC   = MIN_HIGH_DEF,
    parameter int unsigned MAX_HIGH_CYC   = MAX_HIGH_DEF,
    parameter int unsigned RESET_CYC      = LATCH_CYC,
    parameter int unsigned BITS_PER_PIXEL = BITS_PER_PIXEL_DEF,
    parameter int unsigned PX_NUM         = PX_NUM_DEF,
    parameter int unsigned PX_COUNT_WIDTH = PX_COUNT_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    input  logic                      err_clr,
    output logic                      pixel_valid,
    output logic [BITS_PER_PIXEL-1:0] pixel,
    output logic [PX_COUNT_WIDTH-1:0] px_num,
    output logic                      frame_done,
    output logic [PX_COUNT_WIDTH:0]   frame_px_count,
    output logic [2:0]                err,
    output logic                      synced
);

    // The clock rate is informational; every limit below is already in cycles.
    localparam int unsigned clk_hz_unused = CLK_HZ;

    localparam int unsigned HIGH_W = $clog2(MAX_HIGH_CYC) + 1;
    localparam int unsigned LOW_W  = $clog2(RESET_CYC) + 1;
    localparam int unsigned BIT_W  = $clog2(BITS_PER_PIXEL) + 1;
    localparam int unsigned PX_CW  = PX_COUNT_WIDTH + 1;

    localparam logic [HIGH_W-1:0] HIGH_MIN  = HIGH_W'(MIN_HIGH_CYC);
    localparam logic [HIGH_W-1:0] HIGH_THR  = HIGH_W'(BIT_THRESH_CYC);
    localparam logic [HIGH_W-1:0] HIGH_MAX  = HIGH_W'(MAX_HIGH_CYC);
    localparam logic [HIGH_W-1:0] HIGH_LAST = HIGH_W'(MAX_HIGH_CYC - 1);
    localparam logic [LOW_W-1:0]  LOW_MAX   = LOW_W'(RESET_CYC);
    localparam logic [LOW_W-1:0]  LOW_LAST  = LOW_W'(RESET_CYC - 1);
    localparam logic [BIT_W-1:0]  BIT_FULL  = BIT_W'(BITS_PER_PIXEL);
    localparam logic [PX_CW-1:0]  PX_LIMIT  = PX_CW'(PX_NUM);

    logic                      din_s;
    logic                      rise;
    logic                      fall;
    rx_state_t                 state;
    logic [HIGH_W-1:0]         high_cnt;
    logic [LOW_W-1:0]          low_cnt;
    logic [BIT_W-1:0]          bit_cnt;
    logic [BITS_PER_PIXEL-1:0] shift_reg;
    logic [PX_CW-1:0]          px_cnt;

    ws2812_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .din_s (din_s),
        .rise  (rise),
        .fall  (fall)
    );

    // Receiver FSM. A completed pixel is published on the cycle after its last bit
    // is shifted in; any timing fault drops back to S_SYNC and waits for a clean gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_SYNC;
            high_cnt       <= '0;
            low_cnt        <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            px_cnt         <= '0;
            pixel_valid    <= 1'b0;
            pixel          <= '0;
            px_num         <= '0;
            frame_done     <= 1'b0;
            frame_px_count <= '0;
            err            <= '0;
            synced         <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;

            // Later flag writes in this block override the clear, so a fresh error wins.
            if (err_clr) begin
                err <= '0;
            end

            if (bit_cnt == BIT_FULL) begin
                bit_cnt <= '0;
                if (px_cnt < PX_LIMIT) begin
                    pixel       <= shift_reg;
                    px_num      <= px_cnt[PX_COUNT_WIDTH-1:0];
                    pixel_valid <= 1'b1;
                    px_cnt      <= px_cnt + 1'b1;
                end else begin
                    err[ERR_OVERFLOW] <= 1'b1;
                end
            end

            case (state)
                S_SYNC: begin
                    if (din_s) begin
                        low_cnt <= '0;
                    end else if (low_cnt >= LOW_LAST) begin
                        low_cnt <= '0;
                        synced  <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                S_IDLE: begin
                    if (rise) begin
                        high_cnt <= HIGH_W'(1);
                        state    <= S_HIGH;
                    end
                end

                S_HIGH: begin
                    if (fall) begin
                        if (high_cnt < HIGH_MIN) begin
                            err[ERR_TIMING] <= 1'b1;
                            synced          <= 1'b0;
                            low_cnt         <= '0;
                            bit_cnt         <= '0;
                            px_cnt          <= '0;
                            shift_reg       <= '0;
                            state           <= S_SYNC;
                        end else begin
                            shift_reg <= {shift_reg[BITS_PER_PIXEL-2:0], (high_cnt >= HIGH_THR)};
                            bit_cnt   <= bit_cnt + 1'b1;
                            low_cnt   <= LOW_W'(1);
                            state     <= S_LOW;
                        end
                    end else if (high_cnt >= HIGH_LAST) begin
                        high_cnt        <= HIGH_MAX;
                        err[ERR_TIMING] <= 1'b1;
                        synced          <= 1'b0;
                        low_cnt         <= '0;
                        bit_cnt         <= '0;
                        px_cnt          <= '0;
                        shift_reg       <= '0;
                        state           <= S_SYNC;
                    end else begin
                        high_cnt <= high_cnt + 1'b1;
                    end
                end

                S_LOW: begin
                    if (rise) begin
                        high_cnt <= HIGH_W'(1);
                        state    <= S_HIGH;
                    end else if (low_cnt >= LOW_LAST) begin
                        low_cnt        <= LOW_MAX;
                        frame_done     <= 1'b1;
                        frame_px_count <= (px_cnt > PX_LIMIT) ? PX_LIMIT : px_cnt;
                        if (bit_cnt != '0) begin
                            err[ERR_PARTIAL] <= 1'b1;
                        end
                        bit_cnt        <= '0;
                        px_cnt         <= '0;
                        shift_reg      <= '0;
                        state          <= S_IDLE;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed testbench for the WS2812B receiver: table of single-frame pixels plus
// hand-written sequences for alignment, timing faults, latch errors and reset.
module tb_ws2812_rx;
    import ws2812_pkg::*;

    typedef struct {
        logic [23:0] data;
        int unsigned t1h;
        int unsigned t0h;
        int unsigned tlow;
        logic [23:0] exp_pixel;
        logic [5:0]  exp_num;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        din = 1'b0;
    logic        err_clr = 1'b0;
    logic        pixel_valid;
    logic [23:0] pixel;
    logic [5:0]  px_num;
    logic        frame_done;
    logic [6:0]  frame_px_count;
    logic [2:0]  err;
    logic        synced;

    int checks = 0;
    int errors = 0;

    logic [23:0] got_pix[$];
    logic [5:0]  got_num[$];
    int          fd_count = 0;

    vec_t vecs[5];

    ws2812_rx dut (
        .clk            (clk),
        .reset          (reset),
        .din            (din),
        .err_clr        (err_clr),
        .pixel_valid    (pixel_valid),
        .pixel          (pixel),
        .px_num         (px_num),
        .frame_done     (frame_done),
        .frame_px_count (frame_px_count),
        .err            (err),
        .synced         (synced)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    // Record every strobe shortly after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (pixel_valid) begin
            got_pix.push_back(pixel);
            got_num.push_back(px_num);
        end
        if (frame_done) begin
            fd_count++;
        end
    end

    // Compare one observed value against its expected value.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Known pixel pattern for the full-frame tests.
    function automatic logic [23:0] rom(input int i);
        return {2'b00, 6'(i), 8'h00, (8'h01 << (i % 8))};
    endfunction

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_monitor();
        got_pix.delete();
        got_num.delete();
        fd_count = 0;
    endtask

    // One high pulse followed by a low interval.
    task automatic pulse(input int unsigned high_cyc, input int unsigned low_cyc);
        din = 1'b1;
        repeat (high_cyc) @(negedge clk);
        din = 1'b0;
        repeat (low_cyc) @(negedge clk);
    endtask

    // Send the top nbits of data, MSB first.
    task automatic apply_stimulus(input logic [23:0] data, input int nbits, input int unsigned t1h,
                                  input int unsigned t0h, input int unsigned tlow);
        for (int i = nbits - 1; i >= 0; i--) begin
            pulse(data[i] ? t1h : t0h, tlow);
        end
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [23:0] data;
        logic [23:0] seen;

        vecs[0] = '{24'h00FF00, 80, 40, 10, 24'h00FF00, 6'd0};
        vecs[1] = '{24'h0000FF, 80, 40, 10, 24'h0000FF, 6'd1};
        vecs[2] = '{24'h5A5A5A, 60, 59, 6, 24'h5A5A5A, 6'd2};
        vecs[3] = '{24'h800001, 149, 10, 4, 24'h800001, 6'd3};
        vecs[4] = '{grb_pack(8'hA5, 8'hC3, 8'h3C), 70, 20, 3, 24'hA5C33C, 6'd4};

        // Reset state.
        wait_cycles(5);
        check_output("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check_output("rst_pixel", 32'(pixel), 32'd0);
        check_output("rst_px_num", 32'(px_num), 32'd0);
        check_output("rst_frame_done", 32'(frame_done), 32'd0);
        check_output("rst_frame_px_count", 32'(frame_px_count), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_synced", 32'(synced), 32'd0);
        reset = 1'b1;

        // Alignment gap: synced rises without a frame_done.
        wait_cycles(3000);
        check_output("sync_early", 32'(synced), 32'd0);
        wait_cycles(3000);
        check_output("sync_done", 32'(synced), 32'd1);
        check_output("sync_no_frame_done", 32'(fd_count), 32'd0);

        // One nominal pixel, with the strobe latency measured from the last falling edge.
        clear_monitor();
        data = 24'hFF0000;
        for (int i = 23; i >= 1; i--) begin
            pulse(bit_high_cyc(data[i]), bit_low_cyc(data[i]));
        end
        din = 1'b1;
        repeat (bit_high_cyc(data[0])) @(negedge clk);
        din = 1'b0;
        repeat (3) @(negedge clk);
        check_output("latency_early", 32'(pixel_valid), 32'd0);
        @(negedge clk);
        check_output("latency_strobe", 32'(pixel_valid), 32'd1);
        check_output("p1_pixel", 32'(pixel), 32'hFF0000);
        check_output("p1_px_num", 32'(px_num), 32'd0);
        wait_cycles(5020);
        check_output("p1_strobes", 32'(got_pix.size()), 32'd1);
        check_output("p1_frame_done", 32'(fd_count), 32'd1);
        check_output("p1_frame_px_count", 32'(frame_px_count), 32'd1);
        check_output("p1_err", 32'(err), 32'd0);

        // Short glitch in the middle of a pixel.
        clear_monitor();
        apply_stimulus(24'h0000C3, 8, T1H_CYC, T0H_CYC, 45);
        pulse(5, 20);
        check_output("glitch_err", 32'(err), 32'd1);
        check_output("glitch_synced", 32'(synced), 32'd0);
        check_output("glitch_strobes", 32'(got_pix.size()), 32'd0);
        wait_cycles(5050);
        check_output("glitch_resync", 32'(synced), 32'd1);
        check_output("glitch_no_frame_done", 32'(fd_count), 32'd0);
        pulse_err_clr();
        check_output("glitch_err_clr", 32'(err), 32'd0);

        // Table-driven frame, including threshold and width-limit pulses.
        clear_monitor();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].data, 24, vecs[i].t1h, vecs[i].t0h, vecs[i].tlow);
            wait_cycles(4);
            check_output("tbl_strobes", 32'(got_pix.size()), 32'(i + 1));
            check_output("tbl_pixel", 32'(pixel), 32'(vecs[i].exp_pixel));
            check_output("tbl_px_num", 32'(px_num), 32'(vecs[i].exp_num));
        end
        wait_cycles(5020);
        check_output("tbl_frame_done", 32'(fd_count), 32'd1);
        check_output("tbl_frame_px_count", 32'(frame_px_count), 32'd5);
        check_output("tbl_err", 32'(err), 32'd0);

        // Full 52-pixel frame, then a 53rd pixel that must overflow.
        clear_monitor();
        for (int i = 0; i < 52; i++) begin
            apply_stimulus(rom(i), 24, 60, 10, 2);
        end
        wait_cycles(10);
        check_output("rom_strobes", 32'(got_pix.size()), 32'd52);
        check_output("rom_err", 32'(err), 32'd0);
        for (int i = 0; i < 52; i++) begin
            seen = (i < got_pix.size()) ? got_pix[i] : 24'hxxxxxx;
            check_output("rom_pixel", 32'(seen), 32'(rom(i)));
            check_output("rom_px_num", (i < got_num.size()) ? 32'(got_num[i]) : 32'hxxxxxxxx, 32'(i));
        end
        apply_stimulus(rom(52), 24, 60, 10, 2);
        wait_cycles(10);
        check_output("ovf_strobes", 32'(got_pix.size()), 32'd52);
        check_output("ovf_err", 32'(err), 32'd4);
        wait_cycles(5020);
        check_output("ovf_frame_done", 32'(fd_count), 32'd1);
        check_output("ovf_frame_px_count", 32'(frame_px_count), 32'd52);
        pulse_err_clr();
        check_output("ovf_err_clr", 32'(err), 32'd0);

        // Partial pixel at the latch.
        clear_monitor();
        apply_stimulus(24'h000ABC, 12, T1H_CYC, T0H_CYC, 45);
        wait_cycles(5020);
        check_output("part_strobes", 32'(got_pix.size()), 32'd0);
        check_output("part_frame_done", 32'(fd_count), 32'd1);
        check_output("part_frame_px_count", 32'(frame_px_count), 32'd0);
        check_output("part_err", 32'(err), 32'd2);
        pulse_err_clr();
        check_output("part_err_clr", 32'(err), 32'd0);

        // Reset in the middle of pixel 3, then a fresh frame.
        clear_monitor();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(rom(i), 24, 60, 10, 2);
        end
        apply_stimulus(24'h0003FF, 10, 60, 10, 2);
        wait_cycles(2);
        check_output("pre_rst_px_num", 32'(px_num), 32'd2);
        reset = 1'b0;
        #1;
        check_output("mid_rst_pixel", 32'(pixel), 32'd0);
        check_output("mid_rst_px_num", 32'(px_num), 32'd0);
        check_output("mid_rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check_output("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check_output("mid_rst_frame_px_count", 32'(frame_px_count), 32'd0);
        check_output("mid_rst_err", 32'(err), 32'd0);
        check_output("mid_rst_synced", 32'(synced), 32'd0);
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(5050);
        check_output("post_rst_synced", 32'(synced), 32'd1);
        clear_monitor();
        apply_stimulus(24'h123456, 24, T1H_CYC, T0H_CYC, 10);
        wait_cycles(5020);
        check_output("post_rst_strobes", 32'(got_pix.size()), 32'd1);
        check_output("post_rst_pixel", 32'(pixel), 32'h123456);
        check_output("post_rst_px_num", 32'(px_num), 32'd0);
        check_output("post_rst_frame_done", 32'(fd_count), 32'd1);
        check_output("post_rst_frame_px_count", 32'(frame_px_count), 32'd1);

        // Line stuck high past the maximum pulse width.
        din = 1'b1;
        wait_cycles(140);
        check_output("long_high_before", 32'(err), 32'd0);
        wait_cycles(60);
        check_output("long_high_err", 32'(err), 32'd1);
        check_output("long_high_synced", 32'(synced), 32'd0);
        pulse_err_clr();
        check_output("long_high_err_clr", 32'(err), 32'd0);
        din = 1'b0;
        wait_cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
